// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter for a single shared resource.
// The grant is registered and held until the owner pulses done or drops its
// request; on release the arbiter re-arbitrates on the same edge, so a waiting
// client takes over with no idle cycle in between.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   Limits how long one owner may keep the grant to TIMEOUT_CYCLES cycles.
//   When the limit expires the grant is forcibly released and timeout pulses
//   for one cycle. Without the macro there is no hold counter and timeout is 0.
//
// Parameters:
//   NREQ           number of requesters, fixed at 4
//   TIMEOUT_CYCLES maximum hold time in cycles (2..255), timeout build only
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-client request level, held until served
//   done       one-cycle release pulse from the current owner
//   gnt        registered one-hot grant
//   gnt_idx    binary index of the set gnt bit, 0 when idle
//   gnt_valid  high while any grant is active
//   timeout    one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_arbiter4 #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      last;
    logic [1:0]      last_next;
    logic [NREQ-1:0] gnt_next;
    logic [1:0]      idx_next;
    logic            valid_next;

    logic [1:0]      search_start;
    logic [1:0]      cand;
    logic [1:0]      winner;
    logic            found;
    logic            release_grant;
    logic            force_release;

    // An out-of-range hold limit would make the counter compare meaningless.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rr_arbiter4: TIMEOUT_CYCLES must be in 2..255");
    end

    // While a grant is held the search starts just after the owner, which puts
    // the owner itself last; when idle it starts just after the last owner.
    assign search_start = (state == GRANT) ? gnt_idx + 2'd1 : last + 2'd1;

    // Walk the candidates from lowest to highest priority so the final hit
    // is the highest-priority requester.
    always_comb begin
        found  = 1'b0;
        winner = search_start;
        cand   = search_start;
        for (int k = 3; k >= 0; k--) begin
            cand = search_start + 2'(k);
            if (req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign release_grant = done || !req[gnt_idx] || force_release;

    // Next-state and next-grant decode; everything holds unless a grant is
    // made from idle or the current owner releases.
    always_comb begin
        state_next = state;
        last_next  = last;
        gnt_next   = gnt;
        idx_next   = gnt_idx;
        valid_next = gnt_valid;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next       = GRANT;
                    gnt_next         = '0;
                    gnt_next[winner] = 1'b1;
                    idx_next         = winner;
                    valid_next       = 1'b1;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    last_next = gnt_idx;
                    if (found) begin
                        gnt_next         = '0;
                        gnt_next[winner] = 1'b1;
                        idx_next         = winner;
                        valid_next       = 1'b1;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                        idx_next   = 2'd0;
                        valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                idx_next   = 2'd0;
                valid_next = 1'b0;
            end
        endcase
    end

    // State, pointer and grant registers. last resets to 3 so client 0 is
    // first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 2'd3;
            gnt       <= '0;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            gnt       <= gnt_next;
            gnt_idx   <= idx_next;
            gnt_valid <= valid_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] hold_cnt;

    // A forced release only counts when nothing else would have released the
    // grant this cycle; otherwise it is an ordinary release with no pulse.
    assign force_release = (state == GRANT) && (hold_cnt == CNT_MAX) &&
                           !done && req[gnt_idx];

    // The counter restarts on every release (including a re-grant to the same
    // owner) and saturates at the limit while the grant is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_release;
            if (state == GRANT && !release_grant) begin
                if (hold_cnt != CNT_MAX) begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end else begin
                hold_cnt <= 8'd0;
            end
        end
    end
`else
    assign force_release = 1'b0;
    assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter4
// Directed testbench for rr_arbiter4. Each scenario task drives its own
// stimulus and compares the packed outputs {gnt, gnt_idx, gnt_valid, timeout}
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    logic [7:0] obs;
    logic [7:0] exp;
    int         vectors;
    int         misc;

    rr_arbiter4 #(
        .NREQ           (4),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    assign obs = {gnt, gnt_idx, gnt_valid, timeout};

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic logic [7:0] e(input logic [3:0] g, input logic [1:0] i,
                                     input logic v, input logic t);
        return {g, i, v, t};
    endfunction

    // Advance past one rising edge; inputs driven and outputs sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #3;
        exp = e(4'b0000, 2'd0, 1'b0, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL reset_value got %b want %b", obs, exp); end
        tick();
        rst_n = 1'b1;
        tick();
        exp = e(4'b0000, 2'd0, 1'b0, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL idle_after_reset got %b want %b", obs, exp); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0101;
        tick();
        exp = e(4'b0001, 2'd0, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL first_grant got %b want %b", obs, exp); end
        done = 1'b1;
        tick();
        done = 1'b0;
        exp = e(4'b0100, 2'd2, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL handover_no_gap got %b want %b", obs, exp); end
        req = 4'b0000;
        tick();
        exp = e(4'b0000, 2'd0, 1'b0, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL release_to_idle got %b want %b", obs, exp); end
    endtask

    task automatic test_rotation();
        do_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                exp = e(4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0); vectors++;
                if (obs !== exp) begin
                    misc++;
                    $display("[TB] FAIL rotation_g%0d_c%0d got %b want %b", g, c, obs, exp);
                end
                if (c == 2) done = 1'b1;
                tick();
                done = 1'b0;
            end
        end
        req = 4'b0000;
        tick();
        exp = e(4'b0000, 2'd0, 1'b0, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL rotation_idle got %b want %b", obs, exp); end
    endtask

    task automatic test_drop_req();
        do_reset();
        req = 4'b0100;
        tick();
        exp = e(4'b0100, 2'd2, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL owner2_grant got %b want %b", obs, exp); end
        req = 4'b0000;
        tick();
        exp = e(4'b0000, 2'd0, 1'b0, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL drop_to_idle got %b want %b", obs, exp); end
        req = 4'b0001;
        tick();
        exp = e(4'b0001, 2'd0, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL wrap_to_client0 got %b want %b", obs, exp); end
    endtask

    task automatic test_ignored_inputs();
        do_reset();
        done = 1'b1;
        tick();
        done = 1'b0;
        exp = e(4'b0000, 2'd0, 1'b0, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL done_while_idle got %b want %b", obs, exp); end
        req = 4'b0010;
        tick();
        exp = e(4'b0010, 2'd1, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL owner1_grant got %b want %b", obs, exp); end
        req = 4'b1010;
        tick();
        exp = e(4'b0010, 2'd1, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL no_preempt_a got %b want %b", obs, exp); end
        tick();
        exp = e(4'b0010, 2'd1, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL no_preempt_b got %b want %b", obs, exp); end
        done = 1'b1;
        tick();
        done = 1'b0;
        exp = e(4'b1000, 2'd3, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL handover_to_3 got %b want %b", obs, exp); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        tick();
        exp = e(4'b0010, 2'd1, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL pre_reset_grant got %b want %b", obs, exp); end
        #2;
        rst_n = 1'b0;
        #1;
        exp = e(4'b0000, 2'd0, 1'b0, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL async_reset got %b want %b", obs, exp); end
        #1;
        rst_n = 1'b1;
        req   = 4'b0011;
        tick();
        exp = e(4'b0001, 2'd0, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL post_reset_grant got %b want %b", obs, exp); end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            tick();
            exp = e(4'b0001, 2'd0, 1'b1, 1'b0); vectors++;
            if (obs !== exp) begin misc++; $display("[TB] FAIL hold_c%0d got %b want %b", c, obs, exp); end
        end
        tick();
        exp = e(4'b0010, 2'd1, 1'b1, 1'b1); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL timeout_pulse got %b want %b", obs, exp); end
        tick();
        exp = e(4'b0010, 2'd1, 1'b1, 1'b0); vectors++;
        if (obs !== exp) begin misc++; $display("[TB] FAIL timeout_one_cycle got %b want %b", obs, exp); end
`else
        for (int c = 0; c < 10; c++) begin
            tick();
            exp = e(4'b0001, 2'd0, 1'b1, 1'b0); vectors++;
            if (obs !== exp) begin misc++; $display("[TB] FAIL hold_forever_c%0d got %b want %b", c, obs, exp); end
        end
`endif
    endtask

    initial begin
        vectors = 0;
        misc    = 0;
        rst_n   = 1'b0;
        req     = 4'b0000;
        done    = 1'b0;
        test_reset();
        test_back_to_back();
        test_rotation();
        test_drop_req();
        test_ignored_inputs();
        test_async_reset();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
